// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: splits one wide beat into DATA_IN_W/DATA_OUT_W narrow beats, LSB slice first.
// First narrow beat 1 cycle after capture; input ready only while idle or on an accepted last beat.
module ast_width_reducer #(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 16,
  parameter int CHANNEL_W   = 10,
  localparam int EMPTY_IN_W  = ($clog2(DATA_IN_W/8)  > 1) ? $clog2(DATA_IN_W/8)  : 1,
  localparam int EMPTY_OUT_W = ($clog2(DATA_OUT_W/8) > 1) ? $clog2(DATA_OUT_W/8) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int R     = DATA_IN_W / DATA_OUT_W;
  localparam int IB    = DATA_IN_W / 8;
  localparam int OB    = DATA_OUT_W / 8;
  localparam int IDX_W = $clog2(R);

  if ((DATA_IN_W % DATA_OUT_W) != 0 || R < 2 || (DATA_OUT_W % 8) != 0) begin : g_bad_params
    $error("ast_width_reducer: illegal width parameters");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [DATA_IN_W-1:0]   word;
  logic [IDX_W-1:0]       beat;
  logic [IDX_W-1:0]       last_beat;
  logic                   eop_word;
  logic [EMPTY_OUT_W-1:0] last_empty;

  logic [IDX_W-1:0]       cap_last;
  logic [EMPTY_OUT_W-1:0] cap_empty;
  logic [IDX_W-1:0]       beat_nxt;
  logic                   on_last;
  logic                   take_in;

  // Beat count and trailing empty of the word currently offered on the input.
  always_comb begin : size_calc
    int v;
    int n;
    v = IB;
    if (ast_endofpacket_i) begin
      if (int'(ast_empty_i) >= IB) v = 1;
      else                         v = IB - int'(ast_empty_i);
    end
    n         = (v + OB - 1) / OB;
    cap_last  = IDX_W'(n - 1);
    cap_empty = EMPTY_OUT_W'(n * OB - v);
  end

  assign on_last     = (beat == last_beat);
  assign beat_nxt    = beat + IDX_W'(1);
  assign ast_ready_o = srst_i && ((state == IDLE) || (on_last && ast_ready_i));
  assign take_in     = ast_valid_i && ast_ready_o;

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state               <= IDLE;
      word                <= '0;
      beat                <= '0;
      last_beat           <= '0;
      eop_word            <= 1'b0;
      last_empty          <= '0;
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else if (take_in) begin
      // Covers both the idle capture and the bubble-free refill on the last beat.
      state               <= SEND;
      word                <= ast_data_i;
      beat                <= '0;
      last_beat           <= cap_last;
      eop_word            <= ast_endofpacket_i;
      last_empty          <= cap_empty;
      ast_valid_o         <= 1'b1;
      ast_data_o          <= ast_data_i[DATA_OUT_W-1:0];
      ast_startofpacket_o <= ast_startofpacket_i;
      ast_endofpacket_o   <= ast_endofpacket_i && (cap_last == '0);
      ast_empty_o         <= (ast_endofpacket_i && (cap_last == '0)) ? cap_empty : '0;
      ast_channel_o       <= ast_channel_i;
    end else if (state == SEND && ast_ready_i) begin
      if (on_last) begin
        state               <= IDLE;
        ast_valid_o         <= 1'b0;
        ast_startofpacket_o <= 1'b0;
        ast_endofpacket_o   <= 1'b0;
        ast_empty_o         <= '0;
      end else begin
        beat                <= beat_nxt;
        ast_data_o          <= word[beat_nxt*DATA_OUT_W +: DATA_OUT_W];
        ast_startofpacket_o <= 1'b0;
        ast_endofpacket_o   <= eop_word && (beat_nxt == last_beat);
        ast_empty_o         <= (eop_word && (beat_nxt == last_beat)) ? last_empty : '0;
      end
    end
  end

endmodule

// File: doc/ast_width_reducer.md
Name: ast_width_reducer

Overview:
- Avalon-ST width reducer placed directly downstream of ast_width_extender.
- Accepts one wide beat of DATA_IN_W bits and emits it as a sequence of narrow beats of DATA_OUT_W bits.
- Carries sop, eop, channel and empty through the conversion.
- Lets the extended stream be narrowed back onto a byte-oriented sink and gives the bench a loopback path.

Parameters:
- DATA_IN_W, 64: input data width in bits; multiple of DATA_OUT_W; ratio R = DATA_IN_W/DATA_OUT_W must be at least 2.
- DATA_OUT_W, 16: output data width in bits; multiple of 8.
- CHANNEL_W, 10: channel width.
- EMPTY_IN_W, derived: max(1, $clog2(DATA_IN_W/8)).
- EMPTY_OUT_W, derived: max(1, $clog2(DATA_OUT_W/8)).

Ports:
- clk_i  in  1  clock. Single clock domain.
- srst_i  in  1  synchronous, active-low reset; the block is in reset while srst_i is 0.
- ast_data_i  in  DATA_IN_W  input data.
- ast_startofpacket_i  in  1  input sop.
- ast_endofpacket_i  in  1  input eop.
- ast_valid_i  in  1  input valid.
- ast_empty_i  in  EMPTY_IN_W  count of unused bytes in an eop beat.
- ast_channel_i  in  CHANNEL_W  input channel.
- ast_ready_o  out  1  input ready; ready latency 0.
- ast_data_o  out  DATA_OUT_W  output data.
- ast_startofpacket_o  out  1  output sop.
- ast_endofpacket_o  out  1  output eop.
- ast_valid_o  out  1  output valid.
- ast_empty_o  out  EMPTY_OUT_W  count of unused bytes in the last narrow beat.
- ast_channel_o  out  CHANNEL_W  output channel.
- ast_ready_i  in  1  downstream ready.

Behaviour:
- Definitions:
  - IB = DATA_IN_W/8, OB = DATA_OUT_W/8.
  - Transfer on an interface = valid & ready at posedge clk_i.
- Reset (srst_i = 0 at posedge):
  - state goes to IDLE; counters clear.
  - All registered outputs go to 0.
  - ast_ready_o is forced to 0 while srst_i = 0.
  - Any partially emitted word is discarded; no eop is generated for it.
- FSM has two states, IDLE and SEND.
  - IDLE: ast_ready_o = 1. An input transfer captures data, sop, eop, empty and channel, and moves the FSM to SEND. ast_valid_o = 1 from the next cycle, so first-beat latency is 1 cycle.
  - SEND: ast_valid_o = 1. Beat k (k = 0..N-1) outputs ast_data_i[k*DATA_OUT_W +: DATA_OUT_W] of the captured word.
    - Bytes go out LSB-first: the lowest slice is emitted first.
    - A beat advances only on ast_ready_i = 1.
    - Outputs stay stable while ast_ready_i = 0.
- Beat count N:
  - Non-eop word: N = R; ast_empty_i is ignored.
  - eop word: V = IB - ast_empty_i, N = ceil(V/OB). If ast_empty_i >= IB, V is clamped to 1.
- Sideband per beat:
  - ast_startofpacket_o = 1 only on beat 0 of a word captured with sop.
  - ast_endofpacket_o = 1 only on beat N-1 of an eop word.
  - ast_empty_o = N*OB - V on that eop beat and 0 on every other beat.
  - ast_channel_o holds the captured channel for all N beats.
- Back-to-back words:
  - In SEND on beat N-1, ast_ready_o = ast_ready_i. This is combinational from registered state and ast_ready_i.
  - If the last beat and a new input word transfer together, the new word is captured and its beat 0 is presented the next cycle with no bubble.
  - If the last beat transfers with no new input, the FSM returns to IDLE and ast_valid_o = 0 the next cycle.
  - On beats 0..N-2, ast_ready_o = 0.
- Packet framing is not checked: sop/eop are passed through as given, with no error output.
- Throughput: one narrow beat per cycle when ast_ready_i = 1 and input is continuous.

Test Plan:
Bench uses DATA_IN_W=64, DATA_OUT_W=16, CHANNEL_W=10, and keeps srst_i = 1 after reset unless stated.
1. One word, sop=1, eop=1, empty_i=0, data 0x0011223344556677, channel 5, ast_ready_i=1:
   - Beats are 0x6677, 0x4455, 0x2233, 0x0011 on 4 consecutive cycles, starting 1 cycle after the input transfer.
   - sop on beat 0 only; eop on beat 3 only; empty_o = 0; channel_o = 5 on all beats.
2. eop word, empty_i=3 (V=5): exactly 3 beats; eop on beat 2 with empty_o = 1. empty_i=7: exactly 1 beat, eop=1, empty_o=1. empty_i=6 (V=2): 1 beat, empty_o=0.
3. Backpressure: ast_ready_i toggles 1,0,0,1,0,1… during a 4-beat word:
   - data and sideband stay stable while ready_i = 0; each beat appears exactly once; ast_ready_o = 0 until the last beat.
4. Back-to-back: 3-word packet (sop on word 0, eop on word 2, empty_i=0) with continuous input valid and ast_ready_i=1:
   - 12 output beats on 12 consecutive cycles, no valid gap; sop only on beat 0; eop only on beat 11.
5. Reset mid-word: drive srst_i = 0 for one cycle during beat 1:
   - Next cycle ast_valid_o = 0 and all outputs are 0; ast_ready_o = 0 during reset and 1 after.
   - A following single-word packet converts correctly per scenario 1.
6. Loopback: random packets go through ast_width_extender into ast_width_reducer; the output byte stream, sop/eop positions, channel and final empty must match the input scoreboard exactly.
